// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared types and constants for the instruction-fetch stage.
// Rev 1.0
`default_nettype none

package if_fetch_pkg;

  localparam int          INST_W   = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } if_state_e;

endpackage

`default_nettype wire

// File: rtl/if_inst_buf.sv
// if_inst_buf: one-entry {pc,inst} holding buffer used while IF/ID is stalled.
// Rev 1.0
`default_nettype none

module if_inst_buf
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [INST_W-1:0] load_inst,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst
);

  // clear wins so a redirect can never leave a stale entry behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= INST_NOP;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      inst  <= load_inst;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
// if_fetch: PC owner, single-outstanding imem fetch FSM and IF/ID pipeline register.
// Rev 1.0
`default_nettype none

module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          ADDR_W   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst
);

  if_state_e         state;
  logic [ADDR_W-1:0] pc;

  logic              ifid_free;
  logic              rsp_take;
  logic              hold_release;
  logic              buf_load;
  logic              buf_clear;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_pc;
  logic [INST_W-1:0] buf_inst;

  // gated by rst_n so no request is visible while reset is asserted
  assign imem_req_valid = rst_n && (state == S_REQ);
  assign imem_req_addr  = pc;

  assign ifid_free    = !if_valid || !id_stall;
  assign rsp_take     = (state == S_WAIT) && imem_rsp_valid && !redirect_en;
  assign hold_release = (state == S_HOLD) && buf_valid && !id_stall && !redirect_en;
  assign buf_load     = rsp_take && !ifid_free;
  assign buf_clear    = (state == S_HOLD) && (redirect_en || !id_stall);

  if_inst_buf #(
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_pc   (pc),
    .load_inst (imem_rsp_data),
    .valid     (buf_valid),
    .pc        (buf_pc),
    .inst      (buf_inst)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC[ADDR_W-1:0];
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= INST_NOP;
    end else begin
      if (redirect_en) begin
        pc <= redirect_pc;
      end else if (rsp_take) begin
        pc <= pc + ADDR_W'(4);
      end

      // redirect flushes IF/ID but keeps if_pc/if_inst as they were
      if (redirect_en) begin
        if_valid <= 1'b0;
      end else if (rsp_take && ifid_free) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_inst  <= imem_rsp_data;
      end else if (hold_release) begin
        if_valid <= 1'b1;
        if_pc    <= buf_pc;
        if_inst  <= buf_inst;
      end else if (!id_stall) begin
        if_valid <= 1'b0;
      end

      unique case (state)
        S_REQ: begin
          if (!redirect_en && imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (redirect_en) begin
            state <= imem_rsp_valid ? S_REQ : S_DROP;
          end else if (imem_rsp_valid) begin
            state <= ifid_free ? S_REQ : S_HOLD;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state <= S_REQ;
        end
        S_HOLD: begin
          if (redirect_en || !id_stall) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios plus randomized traffic against a transaction-level model.
`default_nettype none

module tb_if_fetch;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_inst;

  if_fetch #(.RESET_PC(RST_PC), .ADDR_W(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level reference: next fetch address, one outstanding fetch
  // (possibly doomed by a redirect), a side queue for stalled instructions.
  logic [63:0] m_pc;
  logic        m_busy;
  logic        m_stale;
  logic        m_ifv;
  logic [63:0] m_ifpc;
  logic [31:0] m_ifinst;
  logic [95:0] m_hold[$];
  int          pend;

  function automatic logic exp_req();
    return rst_n && !m_busy && (m_hold.size() == 0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_busy = 0; m_stale = 0;
    m_ifv = 0; m_ifpc = '0; m_ifinst = NOP;
    m_hold.delete();
    pend = 0;
  endtask

  task automatic check_all();
    chk("req_valid", 64'(imem_req_valid), 64'(exp_req()));
    if (exp_req()) chk("req_addr", imem_req_addr, m_pc);
    chk("if_valid", 64'(if_valid), 64'(m_ifv));
    chk("if_pc", if_pc, m_ifpc);
    chk("if_inst", 64'(if_inst), 64'(m_ifinst));
  endtask

  task automatic model_update(input bit acc);
    bit consumed;
    consumed = m_ifv && !id_stall;
    if (redirect_en) begin
      m_ifv = 0;
      if (m_busy) begin
        if (imem_rsp_valid) begin m_busy = 0; m_stale = 0; end
        else m_stale = 1;
      end
      m_hold.delete();
      m_pc = redirect_pc;
    end else if (m_busy) begin
      if (imem_rsp_valid) begin
        if (!m_stale) begin
          if (!m_ifv || !id_stall) begin
            m_ifv = 1; m_ifpc = m_pc; m_ifinst = imem_rsp_data;
          end else begin
            m_hold.push_back({m_pc, imem_rsp_data});
          end
          m_pc = m_pc + 64'd4;
        end else if (consumed) begin
          m_ifv = 0;
        end
        m_busy = 0; m_stale = 0;
      end else if (consumed) begin
        m_ifv = 0;
      end
    end else if (m_hold.size() != 0) begin
      if (!id_stall) begin
        m_ifv = 1;
        m_ifpc = m_hold[0][95:32];
        m_ifinst = m_hold[0][31:0];
        void'(m_hold.pop_front());
      end
    end else begin
      if (consumed) m_ifv = 0;
      if (acc) m_busy = 1;
    end
  endtask

  // One clock: inputs already driven; advance model, then check at negedge.
  task automatic cycle();
    bit acc;
    acc = exp_req() && imem_req_ready && !redirect_en;
    @(posedge clk);
    model_update(acc);
    if (acc) pend = $urandom_range(1, 3);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] d,
                       input logic re, input logic [63:0] rp, input logic st);
    imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = d;
    redirect_en = re; redirect_pc = rp; id_stall = st;
  endtask

  task automatic rand_drive();
    imem_req_ready = ($urandom_range(0, 3) != 0);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend == 1) begin imem_rsp_valid = 1'b1; pend = 0; end
    else if (pend > 1) pend--;
    redirect_en = ($urandom_range(0, 9) == 0);
    redirect_pc = RST_PC + 64'({$urandom_range(0, 255), 2'b00});
    id_stall    = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all();

    // 1: first fetch and its latency
    @(negedge clk); rst_n = 1'b1; drive(1, 0, 0, 0, 0, 0);
    #1 check_all();
    chk("t1_addr0", imem_req_addr, 64'h8000_0000);
    cycle();
    drive(0, 1, 32'h0000_0513, 0, 0, 0);
    cycle();
    chk("t1_if_valid", 64'(if_valid), 64'd1);
    chk("t1_if_pc", if_pc, 64'h8000_0000);
    chk("t1_if_inst", 64'(if_inst), 64'h0000_0513);
    chk("t1_next_addr", imem_req_addr, 64'h8000_0004);

    // 2: stall while a response arrives
    drive(1, 0, 0, 0, 0, 1); cycle();
    drive(0, 1, 32'h0010_0093, 0, 0, 1); cycle();
    chk("t2_pc_held", if_pc, 64'h8000_0000);
    drive(1, 0, 0, 0, 0, 1); cycle();
    chk("t2_no_req", 64'(imem_req_valid), 64'd0);
    drive(0, 0, 0, 0, 0, 0); cycle();
    chk("t2_if_pc", if_pc, 64'h8000_0004);

    // 3: redirect in wait, stale response dropped
    drive(1, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 1, 64'h8000_0100, 0); cycle();
    drive(0, 1, 32'hdead_beef, 0, 0, 0); cycle();
    chk("t3_if_valid", 64'(if_valid), 64'd0);
    chk("t3_addr", imem_req_addr, 64'h8000_0100);
    drive(1, 0, 0, 0, 0, 0); cycle();
    drive(0, 1, 32'h0020_0113, 0, 0, 0); cycle();
    chk("t3_if_pc", if_pc, 64'h8000_0100);

    // 4: redirect together with response under stall
    drive(1, 0, 0, 0, 0, 1); cycle();
    drive(0, 1, 32'h0030_0193, 1, 64'h8000_0200, 1); cycle();
    chk("t4_if_valid", 64'(if_valid), 64'd0);
    chk("t4_addr", imem_req_addr, 64'h8000_0200);

    // 5: ready withheld, request held stable
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0); cycle();
      chk("t5_valid", 64'(imem_req_valid), 64'd1);
      chk("t5_addr", imem_req_addr, 64'h8000_0200);
    end

    // pc wraps modulo 2^64
    drive(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0); cycle();
    drive(1, 0, 0, 0, 0, 0); cycle();
    drive(0, 1, 32'h0040_0213, 0, 0, 0); cycle();
    chk("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", imem_req_addr, 64'h0);

    // 6: async reset while waiting with IF/ID valid
    drive(1, 0, 0, 0, 0, 1); cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t6_if_valid", 64'(if_valid), 64'd0);
    chk("t6_if_pc", if_pc, 64'h0);
    chk("t6_if_inst", 64'(if_inst), 64'(NOP));
    model_reset();
    @(negedge clk); rst_n = 1'b1; drive(0, 1, 32'h0050_0293, 0, 0, 0);
    #1 check_all();
    cycle();
    chk("t6_late_rsp", 64'(if_valid), 64'd0);
    chk("t6_addr", imem_req_addr, 64'h8000_0000);

    // randomized traffic
    pend = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk); rst_n = 1'b1;
      end
      rand_drive();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
